gp_regfile: RTL

Parametrised general-purpose register file for the VR16 frontend, replacing the fixed four-entry, 16-bit file. It provides a configurable number of registers and width, two combinational read ports with optional write-to-read bypass, and an optional hard-wired zero register. A per-register busy scoreboard lets the issue logic reserve a destination and stall on read-after-write hazards. It sits between decode/issue (read addresses, reservations) and the ALU writeback path.

---
 rtl/vr16_pkg.sv | 12 +
 rtl/gp_scoreboard.sv | 51 +++++
 rtl/gp_regfile.sv | 107 ++++++++++
 3 files changed

// File: rtl/vr16_pkg.sv
// Shared VR16 frontend definitions: default register-file geometry and the
// address/data types used by decode, issue and the ALU writeback path.
package vr16_pkg;

  localparam int VR16_DATA_WIDTH = 16;
  localparam int VR16_NUM_REGS   = 4;
  localparam int VR16_ADDR_WIDTH = $clog2(VR16_NUM_REGS);

  typedef logic [VR16_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [VR16_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/gp_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback clears it.
module gp_scoreboard
  import vr16_pkg::*;
#(
  parameter int NUM_REGS   = VR16_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  reserve_ready
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                reserve_is_zero;

  assign reserve_is_zero = (ZERO_REG != 0) && (reserve_addr == '0);
  assign busy_a          = busy_q[read_addr_a];
  assign busy_b          = busy_q[read_addr_b];

  // Readiness uses the pre-clear busy state; clear first so a same-cycle reserve wins.
  always_comb begin
    reserve_ready = reserve_is_zero | ~busy_q[reserve_addr];
    busy_d        = busy_q;
    if (write_enable) begin
      busy_d[write_addr] = 1'b0;
    end
    if (reserve_valid && reserve_ready && !reserve_is_zero) begin
      busy_d[reserve_addr] = 1'b1;
    end
  end

  // Busy vector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/gp_regfile.sv
// Parametrised VR16 general-purpose register file with two combinational read
// ports, optional write bypass, optional hard-wired zero register and a busy
// scoreboard for read-after-write hazard tracking.
module gp_regfile
  import vr16_pkg::*;
#(
  parameter int DATA_WIDTH = VR16_DATA_WIDTH,
  parameter int NUM_REGS   = VR16_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [ADDR_WIDTH-1:0]          read_addr_a,
  input  logic [ADDR_WIDTH-1:0]          read_addr_b,
  output logic [DATA_WIDTH-1:0]          read_data_a,
  output logic [DATA_WIDTH-1:0]          read_data_b,
  output logic                           busy_a,
  output logic                           busy_b,
  input  logic                           reserve_valid,
  input  logic [ADDR_WIDTH-1:0]          reserve_addr,
  output logic                           reserve_ready,
  output logic                           write_done,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  write_done_q;
  logic                  write_done_d;
  logic                  write_to_zero;
  logic                  bypass_live;

  assign write_to_zero = (ZERO_REG != 0) && (write_addr == '0);
  // Bypass is gated by reset so every read port shows 0 while reset is held.
  assign bypass_live   = (BYPASS != 0) && reset && write_enable;
  assign write_done    = write_done_q;

  // Next-state for storage; writes to the zero register are dropped.
  always_comb begin
    regs_d       = regs_q;
    write_done_d = write_enable;
    if (write_enable && !write_to_zero) begin
      regs_d[write_addr] = write_data;
    end
  end

  // Register storage and write acknowledgement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q       <= '{default: '0};
      write_done_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      write_done_q <= write_done_d;
    end
  end

  // Read ports: zero register overrides bypass, bypass overrides storage.
  always_comb begin
    read_data_a = regs_q[read_addr_a];
    read_data_b = regs_q[read_addr_b];
    if (bypass_live && (write_addr == read_addr_a)) begin
      read_data_a = write_data;
    end
    if (bypass_live && (write_addr == read_addr_b)) begin
      read_data_b = write_data;
    end
    if ((ZERO_REG != 0) && (read_addr_a == '0)) begin
      read_data_a = '0;
    end
    if ((ZERO_REG != 0) && (read_addr_b == '0)) begin
      read_data_b = '0;
    end
  end

  // Flattened debug view of every register.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  gp_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (reset),
    .write_enable  (write_enable),
    .write_addr    (write_addr),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .read_addr_a   (read_addr_a),
    .read_addr_b   (read_addr_b),
    .busy_a        (busy_a),
    .busy_b        (busy_b),
    .reserve_ready (reserve_ready)
  );

endmodule
